step_sequencer_ctrl: RTL and testbench



---
 rtl/step_sequencer_ctrl.sv | 116 +++++++++++
 tb/tb_step_sequencer_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/step_sequencer_ctrl.sv
// step_sequencer_ctrl: programmable N-step sequencer gating per-channel square tones (wr_* register port, pattern_in, led_out, snd_out, step_idx, step_tick)
module step_sequencer_ctrl #(
  parameter int N_STEPS  = 8,
  parameter int N_CH     = 1,
  parameter int CNT_W    = 28,
  parameter int DATA_W   = 32,
  parameter int DEF_STEP = 6250000,
  parameter int DEF_GATE = 3125000,
  parameter int DEF_TONE = 100000,
  localparam int IW      = $clog2(N_STEPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [7:0]              wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [N_CH*N_STEPS-1:0] pattern_in,
  output logic [N_STEPS-1:0]      led_out,
  output logic [N_CH-1:0]         snd_out,
  output logic [IW-1:0]           step_idx,
  output logic                    step_tick
);
  localparam logic [IW-1:0] LAST = IW'(N_STEPS - 1);
  localparam logic [N_STEPS-1:0] TOP = {1'b1, {(N_STEPS-1){1'b0}}};
  logic run_q, run_d, up_q, up_d, tick_q, tick_d;
  logic [1:0] dir_q, dir_d;
  logic [CNT_W-1:0] period_q, period_d, gate_q, gate_d, step_cnt_q, step_cnt_d, wd;
  logic [CNT_W-1:0] half_q [N_CH];
  logic [CNT_W-1:0] half_d [N_CH];
  logic [CNT_W-1:0] tone_cnt_q [N_CH];
  logic [CNT_W-1:0] tone_cnt_d [N_CH];
  logic [N_CH-1:0] tone_q, tone_d, snd_q, snd_d, wr_tone, tone_hit;
  logic [IW-1:0] idx_q, idx_d;
  logic [N_STEPS-1:0] pat;
  logic wr_ctrl, restart, wr_period, term, adv, gate_open, unused_hi;
  assign unused_hi = ^wr_data;
  always_comb begin
    wd = wr_data[CNT_W-1:0];
    wr_ctrl = wr_en && wr_addr == 8'd0;
    restart = wr_ctrl && wr_data[3];
    wr_period = wr_en && wr_addr == 8'd1;
    term = run_q && step_cnt_q == period_q;
    adv = term && !restart && !wr_period;
    gate_open = run_q && step_cnt_q < gate_q;
    run_d = wr_ctrl ? wr_data[0] : run_q;
    dir_d = wr_ctrl ? wr_data[2:1] : dir_q;
    period_d = wr_period ? wd : period_q;
    gate_d = (wr_en && wr_addr == 8'd2) ? wd : gate_q;
    step_cnt_d = (restart || wr_period || term) ? '0 : run_q ? step_cnt_q + CNT_W'(1) : step_cnt_q;
    tick_d = adv;
    idx_d = idx_q;
    up_d = up_q;
    if (restart) begin
      idx_d = dir_d == 2'b01 ? LAST : '0;
      up_d = 1'b1;
    end else begin
      if (adv) begin
        if (dir_q == 2'b01) idx_d = idx_q == '0 ? LAST : idx_q - IW'(1);
        else if (dir_q == 2'b10) begin
          idx_d = up_q ? idx_q + IW'(1) : idx_q - IW'(1);
          up_d = up_q ? idx_d != LAST : idx_d == '0;
        end else idx_d = idx_q == LAST ? '0 : idx_q + IW'(1);
      end
      if (wr_ctrl && dir_d == 2'b10 && dir_q != 2'b10) up_d = idx_d != LAST;
    end
    pat = '0;
    wr_tone = '0;
    tone_hit = '0;
    for (int c = 0; c < N_CH; c++) begin
      wr_tone[c] = wr_en && wr_addr == 8'(3 + c);
      tone_hit[c] = tone_cnt_q[c] == half_q[c];
      half_d[c] = wr_tone[c] ? wd : half_q[c];
      tone_cnt_d[c] = (restart || wr_tone[c] || tone_hit[c]) ? '0 : tone_cnt_q[c] + CNT_W'(1);
      tone_d[c] = (restart || wr_tone[c]) ? 1'b0 : tone_q[c] ^ tone_hit[c];
      pat = pattern_in[c*N_STEPS +: N_STEPS];
      snd_d[c] = gate_open && tone_q[c] && pat[LAST - idx_q];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      dir_q <= 2'b00;
      up_q <= 1'b1;
      tick_q <= 1'b0;
      period_q <= CNT_W'(DEF_STEP);
      gate_q <= CNT_W'(DEF_GATE);
      step_cnt_q <= '0;
      idx_q <= '0;
      tone_q <= '0;
      snd_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        half_q[c] <= CNT_W'(DEF_TONE);
        tone_cnt_q[c] <= '0;
      end
    end else begin
      run_q <= run_d;
      dir_q <= dir_d;
      up_q <= up_d;
      tick_q <= tick_d;
      period_q <= period_d;
      gate_q <= gate_d;
      step_cnt_q <= step_cnt_d;
      idx_q <= idx_d;
      tone_q <= tone_d;
      snd_q <= snd_d;
      for (int c = 0; c < N_CH; c++) begin
        half_q[c] <= half_d[c];
        tone_cnt_q[c] <= tone_cnt_d[c];
      end
    end
  end
  assign led_out = (TOP >> idx_q) | pattern_in[N_STEPS-1:0];
  assign snd_out = snd_q;
  assign step_idx = idx_q;
  assign step_tick = tick_q;
endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// tb_step_sequencer_ctrl: scoreboard bench for step_sequencer_ctrl
module tb_step_sequencer_ctrl;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [7:0] pattern_in = '0;
  logic [7:0] led_out;
  logic [0:0] snd_out;
  logic [2:0] step_idx;
  logic step_tick;
  int checks = 0, errors = 0;
  int q[$];
  always #5 clk = ~clk;
  step_sequencer_ctrl #(
    .N_STEPS(8), .N_CH(1), .CNT_W(28), .DATA_W(32),
    .DEF_STEP(5), .DEF_GATE(2), .DEF_TONE(1)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pattern_in(pattern_in), .led_out(led_out), .snd_out(snd_out),
    .step_idx(step_idx), .step_tick(step_tick)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wr(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = 8'(a);
    wr_data = 32'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic run_seq(input int n, input int per, input int first);
    for (int i = 0; i < n; i++) begin
      int cnt;
      int e;
      logic [7:0] m;
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!step_tick && cnt < 200);
      if (!step_tick) begin
        check("tick_timeout", 0, 1);
        return;
      end
      e = q.pop_front();
      m = 8'h80 >> e;
      check("step_idx", 32'(step_idx), 32'(e));
      check("led", 32'(led_out), 32'(m | pattern_in));
      check("tick_gap", 32'(cnt), 32'(i == 0 ? first : per));
    end
  endtask
  task automatic snd_run(input int ncyc, input int th, input int gl, input int sp, input logic [7:0] pat);
    pattern_in = pat;
    wr(1, sp);
    wr(2, gl);
    wr(3, th);
    wr(0, 9);
    for (int j = 1; j <= ncyc; j++) begin
      int k;
      k = j - 1;
      q.push_back(int'(((k % (sp + 1)) < gl) && ((k / (th + 1)) % 2 == 1) && pat[7 - ((k / (sp + 1)) % 8)]));
    end
    for (int j = 1; j <= ncyc; j++) begin
      @(negedge clk);
      check("snd", 32'(snd_out), 32'(q.pop_front()));
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    check("rst_idx", 32'(step_idx), 0);
    check("rst_tick", 32'(step_tick), 0);
    check("rst_snd", 32'(snd_out), 0);
    check("rst_led", 32'(led_out), 32'h80);
    rst = 1'b0;
    @(negedge clk);
    wr(1, 3);
    wr(0, 1);
    for (int i = 1; i <= 8; i++) q.push_back(i % 8);
    run_seq(8, 4, 4);
    wr(1, 1);
    wr(0, 'hD);
    for (int i = 1; i <= 7; i++) q.push_back(i);
    for (int i = 6; i >= 0; i--) q.push_back(i);
    q.push_back(1);
    q.push_back(2);
    run_seq(16, 2, 2);
    wr(0, 3);
    q.push_back(1);
    q.push_back(0);
    q.push_back(7);
    run_seq(3, 2, 1);
    wr(1, 3);
    q.push_back(6);
    run_seq(1, 4, 4);
    repeat (3) @(negedge clk);
    wr(1, 3);
    check("period_coll_tick", 32'(step_tick), 0);
    check("period_coll_idx", 32'(step_idx), 6);
    q.push_back(5);
    run_seq(1, 4, 4);
    repeat (3) @(negedge clk);
    wr(0, 'hB);
    check("restart_coll_tick", 32'(step_tick), 0);
    check("restart_rev_idx", 32'(step_idx), 7);
    q.push_back(6);
    run_seq(1, 4, 4);
    snd_run(30, 2, 9, 4, 8'hFF);
    snd_run(30, 2, 9, 4, 8'h00);
    snd_run(20, 2, 9, 0, 8'hFF);
    snd_run(30, 2, 9, 20, 8'hFF);
    snd_run(30, 2, 9, 4, 8'h40);
    snd_run(12, 0, 9, 20, 8'hFF);
    pattern_in = 8'h05;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_idx", 32'(step_idx), 0);
    check("arst_tick", 32'(step_tick), 0);
    check("arst_snd", 32'(snd_out), 0);
    check("arst_led", 32'(led_out), 32'h85);
    @(negedge clk);
    rst = 1'b0;
    pattern_in = 8'h00;
    repeat (5) @(negedge clk);
    check("idle_idx", 32'(step_idx), 0);
    check("idle_tick", 32'(step_tick), 0);
    wr(0, 1);
    q.push_back(1);
    run_seq(1, 6, 6);
    repeat (2) @(negedge clk);
    wr(0, 0);
    repeat (8) @(negedge clk);
    check("stop_idx", 32'(step_idx), 1);
    check("stop_tick", 32'(step_tick), 0);
    wr(0, 1);
    q.push_back(2);
    run_seq(1, 6, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
